mode_sequencer: RTL
===================

Name: mode_sequencer

Overview:
- Parametrised successor to the two-mode toggle in the Morse top level.
- Debounces raw mode-select buttons internally on the system clock; no derived slow clock, no button-edge clocking.
- Cycles through N_MODES operating modes (encoder, decoder, future modes).
- Handshakes with the active datapath before committing a mode change: requests a flush, waits for acknowledge or timeout, then updates the mode, one-hot enables and LED indicator.

Parameters:
N_MODES, 2, number of modes; legal range 2..16
DEBOUNCE_CYCLES, 20000, consecutive stable clocks required before a button level is accepted
FLUSH_TIMEOUT, 255, max clocks to wait for flush_ack before forcing commit
MODE_W, $clog2(N_MODES), mode index width (derived localparam)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset (0 = reset)
btn_next  input  1  raw mode-advance button, asynchronous
btn_prev  input  1  raw mode-retreat button (used only with MODE_PREV_EN)
busy  input  1  active datapath is mid-symbol; mode change deferred while high
flush_ack  input  1  datapath has cleared its buffers
flush_req  output  1  level request to datapath to clear buffers
mode  output  MODE_W  current mode index
mode_en  output  N_MODES  one-hot enable, bit[mode]=1
mode_changed  output  1  one-cycle pulse on commit
led_mode  output  N_MODES  LED indicator, equals mode_en

Behaviour:
- Reset (rst=0, async), all outputs valid immediately:
  - mode=0, mode_en=1, led_mode=1, flush_req=0, mode_changed=0.
  - FSM returns to IDLE; debouncers clear to released; pending request cleared.
- Input conditioning, per button:
  - 2-flop synchroniser, then a counter that increments while the synchronised level differs from the accepted level and clears otherwise.
  - At DEBOUNCE_CYCLES the accepted level flips.
  - A rising edge of the accepted level produces a one-cycle press event.
- Request register:
  - A press event sets dir (+1 next, -1 prev) and pend=1.
  - Further presses while pend=1 are dropped; there is no queueing.
  - Simultaneous next and prev press events in the same cycle cancel; pend is not set.
- FSM states: IDLE, WAIT_IDLE, FLUSH, COMMIT.
  - IDLE: pend=1 goes to WAIT_IDLE.
  - WAIT_IDLE: busy=0 goes to FLUSH and asserts flush_req the next cycle.
  - FLUSH: flush_req=1 held until flush_ack=1 or the timeout counter reaches FLUSH_TIMEOUT, then go to COMMIT.
  - COMMIT: single cycle.
    - Mode updates to (mode+dir) mod N_MODES, with wrap N_MODES-1 → 0 and 0 → N_MODES-1.
    - mode_en and led_mode update in the same cycle; mode_changed=1 that cycle.
    - flush_req=0 and pend=0; return to IDLE.
- flush_ack outside FLUSH is ignored. flush_ack already high on FLUSH entry commits after one cycle in FLUSH.
- Latency from press event with busy=0 and immediate ack: 3 clocks to the mode update.
- busy rising during FLUSH has no effect; the flush proceeds.
- Reset mid-FLUSH aborts: flush_req drops asynchronously and mode=0.
- Mode arithmetic uses MODE_W+1 bits internally to avoid overflow when N_MODES is not a power of two. mode never takes a value ≥ N_MODES.

Optional Feature:
- Macro: MODE_PREV_EN.
- Defined: btn_prev gets its own debouncer and issues -1 requests.
- Undefined:
  - btn_prev is ignored and its debouncer is not instantiated.
  - Only forward cycling is possible; the simultaneous-press cancel rule does not apply.

Decomposition:
- Package mode_pkg holds:
  - FSM state enum (IDLE, WAIT_IDLE, FLUSH, COMMIT);
  - mode index constants MODE_ENCODE=0, MODE_DECODE=1;
  - default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce (synchroniser, counter, edge detect), instantiated once or twice.

Test Plan:
1. Reset with rst=0 → mode=0, mode_en=2'b01, led_mode=2'b01, flush_req=0. Release rst → outputs unchanged.
2. N_MODES=3, DEBOUNCE_CYCLES=4, busy=0, ack returned 1 cycle after req, three presses of btn_next → mode 1, 2, 0. Each commit gives exactly one mode_changed pulse; wrap 2→0 observed.
3. btn_next glitches of 3 clocks with DEBOUNCE_CYCLES=4 → no press event, mode stays 0. A 4-clock hold → one change.
4. busy=1 held 50 clocks, then press → flush_req stays 0 until busy falls. Commit 3 clocks after busy=0 with immediate ack.
5. flush_ack tied 0, FLUSH_TIMEOUT=10 → flush_req high for 10 clocks, then forced commit and mode increments.
6. With MODE_PREV_EN, N_MODES=4, mode=0:
   - btn_prev press → mode=3.
   - Simultaneous next and prev press → no change, no flush_req.
   - rst=0 during FLUSH → flush_req=0 and mode=0 immediately.

Source files
------------

// File: rtl/mode_pkg.sv
// Shared definitions for the mode sequencer slice.
//   state_e                 : sequencer FSM states (idle, wait for datapath idle, flush, commit)
//   MODE_ENCODE/MODE_DECODE : indices of the two original Morse modes
//   DEFAULT_DEBOUNCE_CYCLES : default stable-clock count before a button level is accepted
package mode_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWaitIdle,
      StFlush,
      StCommit
   } state_e;

   localparam int unsigned MODE_ENCODE = 0;
   localparam int unsigned MODE_DECODE = 1;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 20000;

endpackage

// File: rtl/mode_sequencer_if.sv
// Handshake bundle between the mode sequencer and the active datapath.
//   busy         : datapath is mid-symbol, mode change must wait
//   flush_ack    : datapath has cleared its buffers
//   flush_req    : level request to clear buffers
//   mode         : current mode index
//   mode_en      : one-hot enable, bit[mode] set
//   mode_changed : one-cycle pulse when a new mode is committed
// Modports: master = sequencer side, slave = datapath side.
interface mode_sequencer_if #(
   parameter int unsigned N_MODES = 2
);

   localparam int unsigned MODE_W = $clog2(N_MODES);

   logic              busy;
   logic              flush_ack;
   logic              flush_req;
   logic [MODE_W-1:0] mode;
   logic [N_MODES-1:0] mode_en;
   logic              mode_changed;

   modport master (
      input  busy,
      input  flush_ack,
      output flush_req,
      output mode,
      output mode_en,
      output mode_changed
   );

   modport slave (
      output busy,
      output flush_ack,
      input  flush_req,
      input  mode,
      input  mode_en,
      input  mode_changed
   );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner running on the system clock.
// A raw asynchronous button is synchronised with two flops, then a counter measures how long
// the synchronised level has differed from the accepted level. After DEBOUNCE_CYCLES
// consecutive differing clocks the accepted level flips; a 0->1 flip emits a one-cycle press.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-low reset (accepted level cleared to released)
//   btn   : raw button level, asynchronous
//   press : one-cycle pulse on an accepted press
module btn_debounce
   import mode_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q == level_q) begin
            // Any return to the accepted level restarts the stability window.
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
            press_q <= sync2_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign press = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: cycles through N_MODES operating modes (encoder, decoder, ...).
// Button presses are debounced on the system clock and latched as a single pending request
// (no queueing). Before a change is committed the sequencer waits for the datapath to go idle,
// raises flush_req and holds it until flush_ack or FLUSH_TIMEOUT clocks, then updates the mode,
// the one-hot enables and the LED indicator together, pulsing mode_changed for one cycle.
// Optional feature (macro MODE_PREV_EN): btn_prev gets its own debouncer and requests -1;
// simultaneous next/prev presses cancel. Without the macro btn_prev is ignored.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   btn_next : raw mode-advance button
//   btn_prev : raw mode-retreat button (MODE_PREV_EN only)
//   dp       : datapath handshake (busy, flush_ack, flush_req, mode, mode_en, mode_changed)
//   led_mode : LED indicator, mirrors mode_en
module mode_sequencer
   import mode_pkg::*;
#(
   parameter int unsigned N_MODES         = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned FLUSH_TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                btn_next,
   input  logic                btn_prev,
   mode_sequencer_if.master    dp,
   output logic [N_MODES-1:0]  led_mode
);

   localparam int unsigned MODE_W  = $clog2(N_MODES);
   // One spare bit so +1 on the last index cannot overflow for non power-of-two N_MODES.
   localparam int unsigned MODE_XW = MODE_W + 1;
   localparam logic [MODE_XW-1:0] MODE_LAST = MODE_XW'(N_MODES - 1);

   localparam int unsigned TMO_W = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FLUSH_TIMEOUT - 1);

   // ---------------------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------------------
   logic next_ev;
   logic req_new;
   logic req_dec;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_next_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_next),
      .press(next_ev)
   );

`ifdef MODE_PREV_EN
   logic prev_ev;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_prev_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_prev),
      .press(prev_ev)
   );

   // Opposite presses in the same cycle cancel each other.
   assign req_new = next_ev ^ prev_ev;
   assign req_dec = prev_ev;
`else
   logic unused_btn_prev;

   assign unused_btn_prev = btn_prev;
   assign req_new         = next_ev;
   assign req_dec         = 1'b0;
`endif

   // ---------------------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------------------
   state_e             state_q;
   logic               pend_q;
   logic               dec_q;
   logic [TMO_W-1:0]   tmo_q;
   logic               flush_req_q;
   logic [MODE_W-1:0]  mode_q;
   logic [N_MODES-1:0] mode_en_q;
   logic               changed_q;

   // ---------------------------------------------------------------------------------------
   // Next mode index with wrap in both directions
   // ---------------------------------------------------------------------------------------
   logic [MODE_XW-1:0] mode_ext;
   logic [MODE_XW-1:0] mode_nxt;

   always_comb begin
      mode_ext = {1'b0, mode_q};
      mode_nxt = mode_ext;
      if (dec_q) begin
         mode_nxt = (mode_ext == '0) ? MODE_LAST : mode_ext - MODE_XW'(1);
      end else begin
         mode_nxt = (mode_ext >= MODE_LAST) ? '0 : mode_ext + MODE_XW'(1);
      end
   end

   // ---------------------------------------------------------------------------------------
   // Sequencer FSM with registered outputs
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         pend_q      <= 1'b0;
         dec_q       <= 1'b0;
         tmo_q       <= '0;
         flush_req_q <= 1'b0;
         mode_q      <= MODE_W'(MODE_ENCODE);
         mode_en_q   <= N_MODES'(1) << MODE_ENCODE;
         changed_q   <= 1'b0;
      end else begin
         changed_q <= 1'b0;

         // A request is latched only when none is pending; later presses are dropped.
         if (req_new && !pend_q) begin
            pend_q <= 1'b1;
            dec_q  <= req_dec;
         end

         unique case (state_q)
            StIdle: begin
               // Acting on the fresh event saves a cycle of press-to-commit latency.
               if (pend_q || req_new) begin
                  state_q <= StWaitIdle;
               end
            end

            StWaitIdle: begin
               if (!dp.busy) begin
                  state_q     <= StFlush;
                  flush_req_q <= 1'b1;
                  tmo_q       <= '0;
               end
            end

            StFlush: begin
               // busy is deliberately not looked at here: an started flush always completes.
               if (dp.flush_ack || (tmo_q == TMO_LAST)) begin
                  state_q     <= StCommit;
                  flush_req_q <= 1'b0;
                  pend_q      <= 1'b0;
                  mode_q      <= mode_nxt[MODE_W-1:0];
                  mode_en_q   <= N_MODES'(1) << mode_nxt;
                  changed_q   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end

            StCommit: begin
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign dp.flush_req    = flush_req_q;
   assign dp.mode         = mode_q;
   assign dp.mode_en      = mode_en_q;
   assign dp.mode_changed = changed_q;
   assign led_mode        = mode_en_q;

endmodule
